// File: rtl/key_resp_deser_if.sv
// rtl/key_resp_deser_if.sv - host-side word handshake for key_resp_deser
interface key_resp_deser_if #(
  parameter int WORD_W = 8
);
  logic [WORD_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;

  modport master (output out_data, output out_valid, input out_ready);
  modport slave  (input out_data, input out_valid, output out_ready);
endinterface

// File: rtl/key_resp_deser.sv
// rtl/key_resp_deser.sv - samples one SDRD bit per qualified read window and packs MSB-first words
// Optional macro KEY_RESP_TIMEOUT_EN: idle timeout discards a stale partial word.
module key_resp_deser #(
  parameter int WORD_W      = 8,
  parameter int SETTLE_CYC  = 2,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   sser,
  input  logic                   ba13,
  input  logic                   ba12,
  input  logic                   br_w,
  input  logic                   sdrd,
  key_resp_deser_if.master       host,
  output logic                   overrun,
  output logic                   busy,
  input  logic                   clr_ovr
);
  typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, WAIT_END} state_t;

  localparam int                CNT_W       = $clog2(WORD_W + 1);
  localparam logic [CNT_W-1:0]  CNT_FULL    = CNT_W'(WORD_W);
  localparam logic [3:0]        SETTLE_LOAD = 4'(SETTLE_CYC - 1);

  state_t            state, state_n;
  logic              win, win_q, rise;
  logic [3:0]        settle_cnt;
  logic [WORD_W-1:0] shift_reg, shift_nxt;
  logic [CNT_W-1:0]  bit_cnt, cnt_inc;
  logic              word_done, load, drop, accept, timeout_hit;

  assign win  = ~sser & ~ba13 & ba12 & br_w;
  assign rise = win & ~win_q;
  assign busy = (bit_cnt != '0);

  // Tracks win even during reset so a window already open at release is not an edge.
  always_ff @(posedge clk) win_q <= win;

  always_comb begin
    state_n   = state;
    shift_nxt = {shift_reg[WORD_W-2:0], sdrd};
    cnt_inc   = bit_cnt + 1'b1;
    word_done = (state == SAMPLE) && (cnt_inc == CNT_FULL);
    load      = word_done && (!host.out_valid || host.out_ready);
    drop      = word_done && !load;
    accept    = host.out_valid && host.out_ready;
    case (state)
      IDLE:     if (rise) state_n = SETTLE;
      SETTLE:   if (!win) state_n = IDLE;
                else if (settle_cnt == 4'd0) state_n = SAMPLE;
      SAMPLE:   state_n = WAIT_END;
      WAIT_END: if (!win) state_n = IDLE;
      default:  state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_ff @(posedge clk) begin
    if (rst)                                    settle_cnt <= 4'd0;
    else if (state == IDLE && rise)             settle_cnt <= SETTLE_LOAD;
    else if (state == SETTLE && settle_cnt != 0) settle_cnt <= settle_cnt - 4'd1;
  end

`ifdef KEY_RESP_TIMEOUT_EN
  localparam int               IDLE_W  = $clog2(TIMEOUT_CYC + 1);
  localparam logic [IDLE_W-1:0] IDLE_TO = IDLE_W'(TIMEOUT_CYC);
  logic [IDLE_W-1:0] idle_cnt;

  assign timeout_hit = (state == IDLE) && (idle_cnt == IDLE_TO);

  always_ff @(posedge clk) begin
    if (rst || rise || bit_cnt == '0 || timeout_hit) idle_cnt <= '0;
    else if (state == IDLE)                          idle_cnt <= idle_cnt + 1'b1;
  end
`else
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      shift_reg <= '0;
      bit_cnt   <= '0;
    end else if (state == SAMPLE) begin
      shift_reg <= shift_nxt;
      bit_cnt   <= word_done ? '0 : cnt_inc;
    end else if (timeout_hit) begin
      shift_reg <= '0;
      bit_cnt   <= '0;
    end
  end

  // A word landing in the same clock as a host accept replaces the old one without a gap.
  always_ff @(posedge clk) begin
    if (rst) begin
      host.out_data  <= '0;
      host.out_valid <= 1'b0;
    end else if (load) begin
      host.out_data  <= shift_nxt;
      host.out_valid <= 1'b1;
    end else if (accept) begin
      host.out_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)          overrun <= 1'b0;
    else if (drop)    overrun <= 1'b1;
    else if (clr_ovr) overrun <= 1'b0;
  end
endmodule

// File: doc/key_resp_deser.md
Name: key_resp_deser

Overview:
- Downstream consumer of the serial key/response decoder GAL in the 93xx protection path.
- Watches the same qualified bus read window that enables that decoder's SDRD output and samples one response bit per access.
- Packs bits MSB-first into a WORD_W-bit word and hands the completed word to the host side over a valid/ready handshake.
- Flags words lost because the host was slow.

Parameters:
- WORD_W, 8: bits per assembled response word (2..16).
- SETTLE_CYC, 2: clocks after window open before SDRD is sampled (1..15).
- TIMEOUT_CYC, 1024: idle clocks that abort a partial word; used only with the optional feature.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- sser  in  1  serial-select strobe, active low.
- ba13  in  1  bus address bit 13.
- ba12  in  1  bus address bit 12.
- br_w  in  1  bus read/not-write, 1 = read.
- sdrd  in  1  serial response bit from the decoder; valid only inside the window.
- out_data  out  WORD_W  assembled word, MSB = first bit sampled.
- out_valid  out  1  out_data holds an unconsumed word.
- out_ready  in  1  host accepts the word.
- overrun  out  1  sticky: a completed word was dropped.
- busy  out  1  partial word in progress (bit count nonzero).
- clr_ovr  in  1  clears overrun.

Behaviour:
- Window: win = ~sser & ~ba13 & ba12 & br_w. Inputs are already synchronous to clk; no synchronizers.
- Reset values: out_data = 0, out_valid = 0, overrun = 0, busy = 0, shift register = 0, bit count = 0, FSM = IDLE.
- FSM states:
  - IDLE: on rising edge of win (win=1, previous win=0), load settle counter = SETTLE_CYC-1, go to SETTLE. A window already high when reset releases is not an edge; it is ignored until win drops and rises again.
  - SETTLE: decrement the counter each clock. When the counter is 0 and win=1, go to SAMPLE. If win drops, return to IDLE with no bit taken (aborted access; shift register and count unchanged).
  - SAMPLE (one clock): shift_reg <= {shift_reg[WORD_W-2:0], sdrd}; count <= count+1; go to WAIT_END.
    - If the new count equals WORD_W, the word is complete: count <= 0.
    - If out_valid=0, or out_valid=1 and out_ready=1 in this same cycle: out_data <= assembled word, out_valid <= 1.
    - Otherwise: drop the new word, set overrun, keep the old out_data.
  - WAIT_END: stay until win=0, then go to IDLE. This gives exactly one bit per access, however long sser is held.
- Sampling latency: the bit is sampled SETTLE_CYC+1 clocks after win rises. With SETTLE_CYC=2, win rising at cycle N gives a sample at the clk edge ending cycle N+3.
- Completed word: out_valid is set on the clock after the last bit's SAMPLE cycle.
- Handshake:
  - out_valid clears on any clock with out_valid & out_ready, unless a new word loads in that same clock; in that case out_valid stays 1 and out_data takes the new word.
  - out_data is stable while out_valid=1 and out_ready=0.
- overrun:
  - Set as above; held until clr_ovr=1 or rst.
  - If clr_ovr and a new overrun occur in the same cycle, the set wins.
- busy = (count != 0).
- rst mid-word discards the partial word and any held word. No output pulses during reset.

Optional Feature:
- Macro: KEY_RESP_TIMEOUT_EN.
- When defined:
  - An idle counter runs while count != 0 and FSM = IDLE, and resets on every window edge.
  - When it reaches TIMEOUT_CYC, count and shift_reg are cleared. This keeps the host in step with the decoder's reset-to-start sequence.
  - A timeout never touches out_data, out_valid or overrun.
- When undefined: the idle counter is absent. A partial word persists indefinitely until completed or rst.

Test Plan:
- Default params: 8 windows each 4 clocks long, sdrd pattern 1,0,1,1,0,0,1,0 -> out_valid rises 1 clk after the 8th sample, out_data = 0xB2, busy falls to 0.
- A single window held 20 clocks with sdrd=1 -> exactly one bit shifted, busy=1 with count 1.
- A window lasting 2 clocks (shorter than SETTLE_CYC+1) -> no bit taken, count unchanged.
- out_ready held 0, 16 windows of all-ones after a 0xB2 word -> second word dropped, overrun=1, out_data stays 0xB2. Then clr_ovr -> overrun=0.
- New word completes in the same clock the host asserts out_ready -> out_valid stays 1, out_data = new word, no overrun.
- With KEY_RESP_TIMEOUT_EN and TIMEOUT_CYC=16: 3 bits, 20 idle clocks, then 8 bits 0x5A -> out_data = 0x5A, not corrupted by the stale bits. Same stimulus without the macro -> out_data = (3 stale bits, then first 5 bits of 0x5A).
